// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_tgt_state_t;

    localparam logic       ACK_BIT             = 1'b0;
    localparam logic       NACK_BIT            = 1'b1;
    localparam logic [6:0] DEFAULT_TARGET_ADDR = 7'h2A;

endpackage

// File: rtl/i2c_target_regfile_if.sv
// Open-drain I2C bus as seen by one target: line levels in, SDA pull-down enable out.
interface i2c_target_regfile_if;
    logic scl;
    logic sda_in;
    logic sda_oe;

    modport slave  (input  scl, input  sda_in, output sda_oe);
    modport master (output scl, output sda_in, input  sda_oe);
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into clk and derives SCL edges plus START/STOP conditions.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_prev_q;
    logic                   sda_prev_q;
    logic                   scl_s;
    logic                   sda_s;

    // Idle bus is high on both lines, so reset to 1 to avoid phantom edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s       = scl_sync_q[SYNC_STAGES-1];
    assign sda_s       = sda_sync_q[SYNC_STAGES-1];
    assign sda_o       = sda_s;
    assign scl_rise_o  = scl_s & ~scl_prev_q;
    assign scl_fall_o  = ~scl_s & scl_prev_q;
    assign start_det_o = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det_o  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with an NREGS x 8 register bank, auto-incrementing pointer and fabric side ports.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = DEFAULT_TARGET_ADDR,
    parameter int         NREGS       = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        IW          = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_target_regfile_if.slave   bus,
    input  logic [IW-1:0]         rd_index_i,
    output logic [7:0]            rd_data_o,
    output logic                  wr_strobe_o,
    output logic [IW-1:0]         wr_index_o,
    output logic [7:0]            wr_data_o,
    output logic                  busy_o
);

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (bus.scl),
        .sda_i       (bus.sda_in),
        .sda_o       (sda_s),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    i2c_tgt_state_t state_q;
    logic [3:0]     cnt_q;
    logic [7:0]     shift_q;
    logic [IW-1:0]  ptr_q;
    logic           ack_on_q;
    logic           rw_q;
    logic           sda_oe_q;
    logic           busy_q;
    logic           wr_strobe_q;
    logic [IW-1:0]  wr_index_q;
    logic [7:0]     wr_data_q;
    logic [7:0]     regs_q [NREGS];
    logic [NREGS-1:0] wr_sel;
    logic [7:0]     rx_byte;
    logic [7:0]     cur_reg;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign cur_reg = regs_q[ptr_q];

    // Bank commits at the end of the strobe cycle, so a same-cycle fabric read sees the old value.
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_wsel
        assign wr_sel[gi] = wr_strobe_q && (wr_index_q == IW'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wr_sel[i]) regs_q[i] <= wr_data_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            ptr_q       <= '0;
            ack_on_q    <= 1'b0;
            rw_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_index_q  <= '0;
            wr_data_q   <= '0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_det) begin
                state_q  <= ST_ADDR;
                cnt_q    <= '0;
                ack_on_q <= 1'b0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else if (stop_det) begin
                state_q  <= ST_IDLE;
                cnt_q    <= '0;
                ack_on_q <= 1'b0;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_ADDR: if (scl_rise) begin
                        shift_q <= rx_byte;
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_q <= '0;
                            if (rx_byte[7:1] == TARGET_ADDR) begin
                                state_q <= ST_ADDR_ACK;
                                rw_q    <= rx_byte[0];
                                busy_q  <= 1'b1;
                            end else begin
                                state_q <= ST_IGNORE;
                            end
                        end
                    end
                    // ACK slot: first SCL fall starts the pull-down, second fall ends it.
                    ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
                        if (!ack_on_q) begin
                            ack_on_q <= 1'b1;
                            sda_oe_q <= ~ACK_BIT;
                        end else begin
                            ack_on_q <= 1'b0;
                            cnt_q    <= '0;
                            sda_oe_q <= 1'b0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_q  <= ST_RDATA;
                                shift_q  <= cur_reg;
                                sda_oe_q <= ~cur_reg[7];
                            end else if (state_q == ST_ADDR_ACK) begin
                                state_q <= ST_PTR;
                            end else begin
                                state_q <= ST_WDATA;
                            end
                        end
                    end
                    ST_PTR: if (scl_rise) begin
                        shift_q <= rx_byte;
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_q   <= '0;
                            ptr_q   <= rx_byte[IW-1:0];
                            state_q <= ST_PTR_ACK;
                        end
                    end
                    ST_WDATA: if (scl_rise) begin
                        shift_q <= rx_byte;
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_q       <= '0;
                            wr_strobe_q <= 1'b1;
                            wr_index_q  <= ptr_q;
                            wr_data_q   <= rx_byte;
                            ptr_q       <= ptr_q + IW'(1);
                            state_q     <= ST_WDATA_ACK;
                        end
                    end
                    // cnt_q counts rising edges; the fall after the 8th hands SDA back.
                    ST_RDATA: if (scl_rise) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) ptr_q <= ptr_q + IW'(1);
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            cnt_q    <= '0;
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_RDATA_ACK;
                        end else begin
                            shift_q  <= {shift_q[6:0], 1'b0};
                            sda_oe_q <= ~shift_q[6];
                        end
                    end
                    ST_RDATA_ACK: if (scl_rise) begin
                        if (sda_s == NACK_BIT) begin
                            state_q <= ST_IGNORE;
                            busy_q  <= 1'b0;
                        end
                    end else if (scl_fall) begin
                        state_q  <= ST_RDATA;
                        cnt_q    <= '0;
                        shift_q  <= cur_reg;
                        sda_oe_q <= ~cur_reg[7];
                    end
                    ST_IGNORE: sda_oe_q <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe  = sda_oe_q;
    assign busy_o      = busy_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_index_o  = wr_index_q;
    assign wr_data_o   = wr_data_q;
    assign rd_data_o   = regs_q[rd_index_i];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench: bit-level I2C master BFM driving the target, with strobe/SDA monitors.
module tb_i2c_target_regfile;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [3:0] rd_index_i = '0;
    logic [7:0] rd_data_o;
    logic       wr_strobe_o;
    logic [3:0] wr_index_o;
    logic [7:0] wr_data_o;
    logic       busy_o;

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;
    logic [3:0] log_idx [64];
    logic [7:0] log_dat [64];
    logic [7:0] log_rd  [64];

    always #5 clk = ~clk;

    i2c_target_regfile_if bus ();
    assign bus.scl    = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    i2c_target_regfile #(.TARGET_ADDR(7'h2A), .NREGS(16), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .rd_index_i  (rd_index_i),
        .rd_data_o   (rd_data_o),
        .wr_strobe_o (wr_strobe_o),
        .wr_index_o  (wr_index_o),
        .wr_data_o   (wr_data_o),
        .busy_o      (busy_o)
    );

    always @(negedge clk) begin
        if (wr_strobe_o && strobe_cnt < 64) begin
            log_idx[strobe_cnt] <= wr_index_o;
            log_dat[strobe_cnt] <= wr_data_o;
            log_rd[strobe_cnt]  <= rd_data_o;
            strobe_cnt          <= strobe_cnt + 1;
        end
        if (bus.sda_oe) oe_cnt <= oe_cnt + 1;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        scl_m = 1'b0; sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic write_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        @(negedge clk);
        b = bus.sda_in;
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        acked = (b == 1'b0);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(nack);
    endtask

    task automatic chk_reg(input logic [3:0] idx, input logic [7:0] exp, input string name);
        rd_index_i = idx;
        @(negedge clk);
        check(name, rd_data_o, exp);
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       exp_ack;
        int         exp_strobes;
        logic [3:0] exp_idx;
    } wvec_t;

    typedef struct {
        logic [3:0] idx;
        logic [7:0] val;
    } rvec_t;

    wvec_t wv [5];
    rvec_t rv [5];

    initial begin
        logic       a0, a1, a2;
        logic [7:0] b0, b1;
        int         s0, o0;

        wv[0] = '{7'h2A, 8'h03, 8'h06, 1'b1, 1, 4'd3};
        wv[1] = '{7'h2B, 8'h04, 8'h55, 1'b0, 0, 4'd0};
        wv[2] = '{7'h2A, 8'h17, 8'h99, 1'b1, 1, 4'd7};
        wv[3] = '{7'h00, 8'h01, 8'h77, 1'b0, 0, 4'd0};
        wv[4] = '{7'h2A, 8'h08, 8'hC3, 1'b1, 1, 4'd8};
        rv[0] = '{4'd3, 8'h06};
        rv[1] = '{4'd4, 8'h00};
        rv[2] = '{4'd7, 8'h99};
        rv[3] = '{4'd8, 8'hC3};
        rv[4] = '{4'd1, 8'h00};

        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        wait_q();
        check("rst_sda_oe", bus.sda_oe, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_wr_strobe", wr_strobe_o, 1'b0);
        check("rst_wr_index", wr_index_o, 4'd0);
        check("rst_wr_data", wr_data_o, 8'h00);
        chk_reg(4'd0, 8'h00, "rst_reg0");
        $display("reset: sda_oe=%0b busy=%0b", bus.sda_oe, busy_o);

        for (int v = 0; v < 5; v++) begin
            s0 = strobe_cnt;
            o0 = oe_cnt;
            i2c_start();
            write_byte({wv[v].addr, 1'b0}, a0);
            check("addr_ack", a0, wv[v].exp_ack);
            write_byte(wv[v].ptr, a1);
            write_byte(wv[v].data, a2);
            i2c_stop();
            wait_q();
            check("strobe_count", strobe_cnt - s0, wv[v].exp_strobes);
            check("busy_after_stop", busy_o, 1'b0);
            if (!wv[v].exp_ack) begin
                check("oe_quiet", oe_cnt - o0, 0);
            end else begin
                check("ptr_ack", a1, 1'b1);
                check("data_ack", a2, 1'b1);
                check("wr_idx", log_idx[s0], wv[v].exp_idx);
                check("wr_data", log_dat[s0], wv[v].data);
            end
            $display("write addr=%02h ptr=%02h data=%02h ack=%0b strobes=%0d",
                     wv[v].addr, wv[v].ptr, wv[v].data, a0, strobe_cnt - s0);
        end

        for (int r = 0; r < 5; r++) chk_reg(rv[r].idx, rv[r].val, "reg_readback");

        // Pointer wrap across the top of the bank; fabric reads reg15 during its own strobe.
        rd_index_i = 4'd15;
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h54, a0);
        check("wrap_busy", busy_o, 1'b1);
        write_byte(8'h0F, a1);
        write_byte(8'hA1, a2);
        write_byte(8'hB2, a2);
        i2c_stop();
        wait_q();
        check("wrap_strobes", strobe_cnt - s0, 2);
        check("wrap_idx0", log_idx[s0], 4'd15);
        check("wrap_dat0", log_dat[s0], 8'hA1);
        check("wrap_old_rd", log_rd[s0], 8'h00);
        check("wrap_idx1", log_idx[s0+1], 4'd0);
        check("wrap_dat1", log_dat[s0+1], 8'hB2);
        chk_reg(4'd15, 8'hA1, "wrap_reg15");
        chk_reg(4'd0, 8'hB2, "wrap_reg0");
        $display("wrap: strobes=%0d", strobe_cnt - s0);

        // Load reg5/reg6, then pointer write + repeated START + two-byte read.
        i2c_start();
        write_byte(8'h54, a0);
        write_byte(8'h05, a1);
        write_byte(8'h5A, a2);
        write_byte(8'hC7, a2);
        i2c_stop();
        i2c_start();
        write_byte(8'h54, a0);
        write_byte(8'h05, a1);
        i2c_start();
        write_byte(8'h55, a0);
        check("rd_addr_ack", a0, 1'b1);
        read_byte(b0, 1'b0);
        read_byte(b1, 1'b1);
        check("rd_byte0", b0, 8'h5A);
        check("rd_byte1", b1, 8'hC7);
        check("rd_nack_busy", busy_o, 1'b0);
        check("rd_nack_oe", bus.sda_oe, 1'b0);
        i2c_stop();
        $display("read: ptr=05 bytes=%02h %02h", b0, b1);

        // Partial byte then STOP must be discarded.
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h54, a0);
        write_byte(8'h09, a1);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        i2c_stop();
        wait_q();
        check("partial_strobes", strobe_cnt - s0, 0);
        check("partial_oe", bus.sda_oe, 1'b0);
        check("partial_busy", busy_o, 1'b0);
        chk_reg(4'd9, 8'h00, "partial_reg9");
        i2c_start();
        write_byte(8'h54, a0);
        write_byte(8'h09, a1);
        write_byte(8'h3C, a2);
        i2c_stop();
        wait_q();
        check("after_partial_ack", a2, 1'b1);
        check("after_partial_strobes", strobe_cnt - s0, 1);
        chk_reg(4'd9, 8'h3C, "after_partial_reg9");
        $display("partial: strobes=%0d reg9=%02h", strobe_cnt - s0, rd_data_o);

        // Reset while the target is pulling SDA low for the address ACK.
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : (((8'h54 >> i) & 8'h01) != 0));
        sda_m = 1'b1;
        @(negedge clk);
        check("ack_oe_before_rst", bus.sda_oe, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_oe_async", bus.sda_oe, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy_mid", busy_o, 1'b0);
        for (int i = 0; i < 16; i++) chk_reg(4'(i), 8'h00, "rst_reg_clear");
        scl_m = 1'b1;
        wait_q();
        i2c_stop();
        $display("reset-mid-ack: sda_oe=%0b busy=%0b", bus.sda_oe, busy_o);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
